// File: rtl/scan_decoder_if.sv
// Bus bundle for scan_decoder: control/data inputs and decoded select outputs.
//   en       global enable
//   mode     00 off, 01 direct, 10 continuous scan, 11 single sweep
//   sel      channel select for direct mode
//   data_in  one data bit per channel
//   y_n      active-low select lines, y_n[i]=0 means channel i active
//   mux_out  data of the active channel, 0 when none is active
//   cur_idx  currently selected channel index
//   busy     high while a sweep is in progress
//   done     one-cycle pulse on sweep completion
interface scan_decoder_if #(
  parameter int unsigned SEL_W = 2
);
  localparam int unsigned NCH = 2 ** SEL_W;

  logic             en;
  logic [1:0]       mode;
  logic [SEL_W-1:0] sel;
  logic [NCH-1:0]   data_in;
  logic [0:NCH-1]   y_n;
  logic             mux_out;
  logic [SEL_W-1:0] cur_idx;
  logic             busy;
  logic             done;

  modport master (
    output en, mode, sel, data_in,
    input  y_n, mux_out, cur_idx, busy, done
  );

  modport slave (
    input  en, mode, sel, data_in,
    output y_n, mux_out, cur_idx, busy, done
  );
endinterface

// File: rtl/scan_decoder.sv
// Registered active-low decoder with channel mux, direct / auto-scan / single-sweep.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    scan_decoder_if.slave (en, mode, sel, data_in in; y_n, mux_out,
//          cur_idx, busy, done out)
// All outputs are registered; they reflect the inputs sampled at the previous edge.
module scan_decoder #(
  parameter int unsigned SEL_W = 2,
  parameter int unsigned DWELL = 4
) (
  input logic           clk,
  input logic           rst_n,
  scan_decoder_if.slave bus
);

  localparam int unsigned      NCH      = 2 ** SEL_W;
  localparam int unsigned      CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(NCH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIRECT,
    ST_SCAN,
    ST_SWEEP,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [0:NCH-1]   y_n_q, y_n_d;
  logic             mux_q, mux_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             act_d;

  // Dwell stepping shared by scan and sweep: advance channel after the last dwell cycle.
  logic             dwell_end;
  logic [CNT_W-1:0] cnt_step;
  logic [SEL_W-1:0] idx_step;

  assign dwell_end = (cnt_q == CNT_LAST);
  assign cnt_step  = dwell_end ? '0 : cnt_q + CNT_W'(1);
  assign idx_step  = dwell_end ? idx_q + SEL_W'(1) : idx_q;

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      y_n_q   <= '1;
      mux_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      y_n_q   <= y_n_d;
      mux_q   <= mux_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    act_d   = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    y_n_d   = '1;
    mux_d   = 1'b0;

    case (bus.mode)
      2'b00: begin
        state_d = ST_IDLE;
      end
      2'b01: begin
        state_d = ST_DIRECT;
        if (bus.en) begin
          idx_d = bus.sel;
          act_d = 1'b1;
        end
      end
      2'b10: begin
        state_d = ST_SCAN;
        if (state_q != ST_SCAN) begin
          // Entry edge shows channel 0 as its first dwell cycle.
          idx_d = '0;
          cnt_d = '0;
          act_d = bus.en;
        end else if (bus.en) begin
          idx_d = idx_step;
          cnt_d = cnt_step;
          act_d = 1'b1;
        end
      end
      default: begin
        if (state_q == ST_DONE) begin
          // Parked until mode leaves 11.
          state_d = ST_DONE;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (state_q != ST_SWEEP) begin
          state_d = ST_SWEEP;
          idx_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          act_d   = bus.en;
        end else if (!bus.en) begin
          state_d = ST_SWEEP;
          busy_d  = 1'b1;
        end else if (dwell_end && (idx_q == IDX_LAST)) begin
          state_d = ST_DONE;
          idx_d   = '0;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          state_d = ST_SWEEP;
          idx_d   = idx_step;
          cnt_d   = cnt_step;
          busy_d  = 1'b1;
          act_d   = 1'b1;
        end
      end
    endcase

    for (int unsigned i = 0; i < NCH; i++) begin
      y_n_d[i] = !(act_d && (idx_d == SEL_W'(i)));
    end
    mux_d = act_d & bus.data_in[idx_d];
  end

  assign bus.y_n     = y_n_q;
  assign bus.mux_out = mux_q;
  assign bus.cur_idx = idx_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: doc/scan_decoder.md
Name: scan_decoder

Overview:
Parametrised, registered successor to the team's combinational active-low decoder and 2:1 mux. Drives NCH = 2**SEL_W active-low select lines and routes the matching data channel to a single output. Three operating modes:
- direct decode from an external select
- continuous auto-scan with a programmable dwell time
- single sweep with completion pulse

Sits in front of multiplexed display and keypad-scan logic.

Parameters:
SEL_W, 2, select width; channel count NCH = 2**SEL_W (SEL_W >= 1)
DWELL, 4, cycles each channel stays active in scan/sweep modes (DWELL >= 1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  global enable; 0 forces outputs inactive and pauses scan/sweep
mode  input  2  00 off, 01 direct, 10 continuous scan, 11 single sweep
sel  input  SEL_W  channel select, used in direct mode only
data_in  input  NCH  one data bit per channel
y_n  output  [0:NCH-1]  active-low select lines; y_n[i]=0 means channel i active
mux_out  output  1  data_in[cur_idx] when a channel is active, else 0
cur_idx  output  SEL_W  currently selected channel index
busy  output  1  1 while a sweep is in progress
done  output  1  one-cycle pulse when a sweep completes

Behaviour:
- Reset (rst_n=0, asynchronous, any state):
  - y_n all ones, mux_out 0, cur_idx 0, busy 0, done 0
  - dwell counter 0, state IDLE
- All outputs are registered. Output changes appear on the clock edge after the input or state change (1-cycle latency).
- States: IDLE, DIRECT, SCAN, SWEEP, DONE.
- State selection, evaluated every edge:
  - mode 00 -> IDLE
  - 01 -> DIRECT
  - 10 -> SCAN
  - 11 -> SWEEP, then DONE after completion; stays DONE while mode remains 11
- Entering SCAN or SWEEP from any other state clears cur_idx and the dwell counter to 0.
- Re-entering SWEEP requires passing through another mode first.
- IDLE: y_n all ones, mux_out 0, cur_idx holds.
- DIRECT:
  - en=1: cur_idx <= sel; y_n <= active-low one-hot of sel; mux_out <= data_in[sel]
  - en=0: y_n all ones, mux_out 0, cur_idx holds
- SCAN:
  - en=1: channel cur_idx active for exactly DWELL consecutive cycles; dwell counter counts 0..DWELL-1, then cur_idx increments
  - cur_idx wraps from NCH-1 to 0 and scanning continues indefinitely
  - en=0: counter and cur_idx freeze, y_n all ones, mux_out 0; en=1 resumes mid-dwell from the frozen count
- SWEEP:
  - busy=1; same stepping and en behaviour as SCAN, but no wrap
  - after the last dwell cycle of channel NCH-1: done=1 for one cycle, busy=0, state DONE
- DONE: y_n all ones, mux_out 0, busy 0, cur_idx 0.
- Mode change mid-dwell or mid-sweep:
  - abandons the current operation at the next edge; no done pulse
  - busy drops on that edge
- DWELL=1: cur_idx advances every enabled cycle.
- Dwell counter width: clog2(DWELL), minimum 1 bit.
- Invariant: never more than one y_n bit is low. All ones whenever en=0 or state is IDLE/DONE.
- mux_out tracks data_in of the active channel every cycle, so a data change during a dwell is reflected with 1-cycle latency.

Test Plan:
- Reset mid-scan, SEL_W=2, DWELL=3: assert rst_n=0 asynchronously -> y_n=1111, mux_out=0, cur_idx=0, busy=0 immediately, without waiting for a clock edge.
- Direct mode, en=1, sel stepped 0..3 one per cycle, data_in=4'b1010 -> y_n = 0111, 1011, 1101, 1110 one cycle after each sel; mux_out follows data_in[sel]: 0,1,0,1 (sel 0 -> 0, sel 1 -> 1, sel 2 -> 0, sel 3 -> 1). en=0 -> 1111 next cycle.
- Scan, DWELL=3, en=1 for 14 cycles:
  - each y_n pattern held exactly 3 cycles in order 0111, 1011, 1101, 1110
  - wraps to 0111 at cycle 13
  - done never asserted
- Scan pause: drop en for 5 cycles during channel 2, second dwell cycle -> y_n=1111 while paused; on resume channel 2 stays active for 1 more cycle, then moves to channel 3.
- Sweep, DWELL=3, mode=11 held:
  - busy=1 for 12 cycles covering channels 0..3
  - done=1 for exactly one cycle, then busy=0 and y_n=1111
  - no restart until mode leaves 11 and returns
- Sweep abort: switch mode 11->01 during channel 1 -> busy=0 next edge, no done pulse, y_n follows sel.
